minmax_tracker: RTL and testbench
=================================

// Module: minmax_tracker
// PURPOSE
//   Streaming signed min/max tracker that consumes packets of N-bit samples.
//   Sits downstream of comparator_lt / comparator_eq: one instance of each
//   compares every new sample against the running min and max.
//   Emits one result per packet: min, max, their first indices, sample count.
//   Valid/ready handshake on both input and output sides.
// PARAMETERS
//   N      32  sample width; samples are two's-complement signed
//   IDX_W  16  width of index and count fields
// PORTS
//   clk          in   1      single clock, rising edge
//   rst_n        in   1      asynchronous, active-low reset
//   in_valid     in   1      in_data / in_last are valid this cycle
//   in_ready     out  1      block accepts a sample this cycle
//   in_data      in   N      signed sample
//   in_last      in   1      sample is the final one of its packet
//   out_valid    out  1      result registers hold a finished packet
//   out_ready    in   1      consumer takes the result this cycle
//   out_min      out  N      smallest sample (signed)
//   out_max      out  N      largest sample (signed)
//   out_min_idx  out  IDX_W  index of the first occurrence of out_min
//   out_max_idx  out  IDX_W  index of the first occurrence of out_max
//   out_count    out  IDX_W  samples in the packet (saturating)
// BEHAVIOUR
//   - Accept = in_valid & in_ready. Transfer = out_valid & out_ready.
//   - Reset (rst_n=0, async): state=S_IDLE; all out_* regs = 0;
//     out_valid = 0; in_ready = 1 from the first edge after release.
//   - FSM with three states:
//     S_IDLE : in_ready=1. On accept: min=max=in_data, min_idx=max_idx=0,
//              count=1. Go to S_DONE if in_last, else S_ACCUM.
//     S_ACCUM: in_ready=1. On accept, with i = current count:
//              if in_data <s min: min=in_data, min_idx=i.
//              if max <s in_data: max=in_data, max_idx=i.
//              count=count+1. Go to S_DONE if in_last.
//     S_DONE : in_ready=0, out_valid=1. On transfer, go to S_IDLE.
//   - Ties keep the earlier index: strict-less compare only.
//     comparator_eq drives equality; it never updates an index.
//   - Compares are signed: 32'h80000000 < 32'h7FFFFFFF.
//   - Latency: out_valid rises on the edge that accepts the in_last sample.
//     Registered output; no combinational path from input to output.
//   - While out_valid=1, out_* hold stable until the transfer cycle,
//     and stay stable after it until the next packet completes.
//   - in_ready is 0 in S_DONE, so no sample is taken in the transfer cycle.
//     A new packet may start the cycle after the transfer.
//   - Bubbles (in_valid=0) leave all state unchanged in every state.
//   - Saturation: count stops at 2^IDX_W-1. Later samples still update
//     min/max; their index is recorded as 2^IDX_W-1.
//   - Reset mid-packet drops the partial packet; no result is emitted.
//   - in_data / in_last are ignored when in_valid=0 (X-tolerant).
// TESTING
//   1 Packet {5,-3,7,-3,7}, in_last on the 5th sample -> out_min=-3,
//     out_min_idx=1, out_max=7, out_max_idx=2, out_count=5,
//     out_valid=1 on the cycle after the last accept.
//   2 Single sample -7 with in_last=1 -> min=max=-7, both idx=0,
//     out_count=1, in_ready=0 until out_ready=1.
//   3 Packet {32'h7FFFFFFF, 32'h80000000, 0} -> out_min=32'h80000000 (idx 1),
//     out_max=32'h7FFFFFFF (idx 0).
//   4 Hold out_ready=0 for 4 cycles after completion -> out_* stable,
//     out_valid=1, in_ready=0. Then out_ready=1 -> next cycle out_valid=0,
//     in_ready=1.
//   5 Accept 2 samples, pull rst_n low mid-cycle -> out_valid=0 and
//     outputs=0 immediately. After release, packet {1,2} with last -> min=1,
//     max=2, count=2; the earlier data has no effect.
//   6 Random packets (1-20 samples, random in_valid/out_ready gaps)
//     -> match a behavioural model; count mismatches, report pass/fail.

Source files
------------

// File: rtl/minmax_tracker.sv
// minmax_tracker
//   Streaming signed min/max tracker. Consumes packets of N-bit two's-complement
//   samples and emits one result per packet: the smallest and largest sample,
//   the index of the first occurrence of each, and a saturating sample count.
//
// Ports
//   clk          in   1      clock, rising edge
//   rst_n        in   1      asynchronous, active-low reset
//   in_valid     in   1      in_data / in_last valid this cycle
//   in_ready     out  1      block accepts a sample this cycle
//   in_data      in   N      signed sample
//   in_last      in   1      final sample of its packet
//   out_valid    out  1      result registers hold a finished packet
//   out_ready    in   1      consumer takes the result this cycle
//   out_min      out  N      smallest sample (signed)
//   out_max      out  N      largest sample (signed)
//   out_min_idx  out  IDX_W  index of first occurrence of out_min
//   out_max_idx  out  IDX_W  index of first occurrence of out_max
//   out_count    out  IDX_W  samples in the packet (saturating)
//
// State  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for the first sample of a packet
// S_ACCUM| packet in progress, folding samples into running min/max
// S_DONE | result held on out_*, waiting for the consumer to take it

module minmax_tracker #(
  parameter int N     = 32,
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_min,
  output logic [N-1:0]     out_max,
  output logic [IDX_W-1:0] out_min_idx,
  output logic [IDX_W-1:0] out_max_idx,
  output logic [IDX_W-1:0] out_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] CNT_MAX = '1;

  state_t state;

  // Running accumulators are kept apart from the out_* registers so a
  // finished result stays stable while the next packet is accumulating.
  logic [N-1:0]     acc_min;
  logic [N-1:0]     acc_max;
  logic [IDX_W-1:0] acc_min_idx;
  logic [IDX_W-1:0] acc_max_idx;
  logic [IDX_W-1:0] acc_count;

  logic [N-1:0]     nxt_min;
  logic [N-1:0]     nxt_max;
  logic [IDX_W-1:0] nxt_min_idx;
  logic [IDX_W-1:0] nxt_max_idx;
  logic [IDX_W-1:0] nxt_count;

  logic accept;
  logic transfer;
  logic data_lt_min;
  logic max_lt_data;

  assign accept   = in_valid & in_ready;
  assign transfer = out_valid & out_ready;

  // Strict-less compares only: an equal sample never moves an index, so the
  // first occurrence wins.
  assign data_lt_min = $signed(in_data) < $signed(acc_min);
  assign max_lt_data = $signed(acc_max) < $signed(in_data);

  always_comb begin
    nxt_min     = acc_min;
    nxt_max     = acc_max;
    nxt_min_idx = acc_min_idx;
    nxt_max_idx = acc_max_idx;
    nxt_count   = acc_count;
    if (state == S_IDLE) begin
      nxt_min     = in_data;
      nxt_max     = in_data;
      nxt_min_idx = '0;
      nxt_max_idx = '0;
      nxt_count   = IDX_W'(1);
    end else begin
      // acc_count is the index of the incoming sample; once it saturates,
      // later samples are all recorded at the saturated index.
      if (data_lt_min) begin
        nxt_min     = in_data;
        nxt_min_idx = acc_count;
      end
      if (max_lt_data) begin
        nxt_max     = in_data;
        nxt_max_idx = acc_count;
      end
      if (acc_count != CNT_MAX) begin
        nxt_count = acc_count + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      acc_min     <= '0;
      acc_max     <= '0;
      acc_min_idx <= '0;
      acc_max_idx <= '0;
      acc_count   <= '0;
      out_min     <= '0;
      out_max     <= '0;
      out_min_idx <= '0;
      out_max_idx <= '0;
      out_count   <= '0;
    end else begin
      case (state)
        S_IDLE, S_ACCUM: begin
          in_ready <= 1'b1;
          if (accept) begin
            acc_min     <= nxt_min;
            acc_max     <= nxt_max;
            acc_min_idx <= nxt_min_idx;
            acc_max_idx <= nxt_max_idx;
            acc_count   <= nxt_count;
            if (in_last) begin
              out_min     <= nxt_min;
              out_max     <= nxt_max;
              out_min_idx <= nxt_min_idx;
              out_max_idx <= nxt_max_idx;
              out_count   <= nxt_count;
              out_valid   <= 1'b1;
              in_ready    <= 1'b0;
              state       <= S_DONE;
            end else begin
              state <= S_ACCUM;
            end
          end
        end
        S_DONE: begin
          in_ready <= 1'b0;
          if (transfer) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minmax_tracker.sv
module tb_minmax_tracker;

  localparam int N     = 32;
  localparam int IDX_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_min;
  logic [N-1:0]     out_max;
  logic [IDX_W-1:0] out_min_idx;
  logic [IDX_W-1:0] out_max_idx;
  logic [IDX_W-1:0] out_count;

  int n_checks = 0;
  int n_fail   = 0;

  minmax_tracker #(.N(N), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_min    (out_min),
    .out_max    (out_max),
    .out_min_idx(out_min_idx),
    .out_max_idx(out_max_idx),
    .out_count  (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All tasks start and finish 1 time unit after a rising edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [N-1:0] d, input logic l);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      tick(1);
      t++;
    end
    if (t >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    tick(1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic drain();
    int t;
    out_ready = 1'b1;
    t = 0;
    while (out_valid !== 1'b1 && t < 50) begin
      tick(1);
      t++;
    end
    if (t >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: out_valid=%b required 1", out_valid);
    end
    tick(1);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    tick(3);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_min !== '0 || out_max !== '0) begin n_fail++; $display("FAIL reset_minmax: got %h/%h want 0/0", out_min, out_max); end
    n_checks++; if (out_min_idx !== '0 || out_max_idx !== '0 || out_count !== '0) begin
      n_fail++; $display("FAIL reset_idx_count: got %0d/%0d/%0d want 0/0/0", out_min_idx, out_max_idx, out_count); end
    rst_n = 1'b1;
    tick(1);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    send(32'd5, 1'b0);
    send(-32'sd3, 1'b0);
    send(32'd7, 1'b0);
    send(-32'sd3, 1'b0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
    send(32'd7, 1'b1);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    n_checks++; if (out_min !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL basic_min: got %0d want -3", $signed(out_min)); end
    n_checks++; if (out_min_idx !== 4'd1) begin n_fail++; $display("FAIL basic_min_idx: got %0d want 1", out_min_idx); end
    n_checks++; if (out_max !== 32'd7) begin n_fail++; $display("FAIL basic_max: got %0d want 7", $signed(out_max)); end
    n_checks++; if (out_max_idx !== 4'd2) begin n_fail++; $display("FAIL basic_max_idx: got %0d want 2", out_max_idx); end
    n_checks++; if (out_count !== 4'd5) begin n_fail++; $display("FAIL basic_count: got %0d want 5", out_count); end
    drain();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_after_transfer: valid=%b ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_single();
    send(-32'sd7, 1'b1);
    n_checks++; if (out_min !== 32'hFFFF_FFF9 || out_max !== 32'hFFFF_FFF9) begin
      n_fail++; $display("FAIL single_minmax: got %0d/%0d want -7/-7", $signed(out_min), $signed(out_max)); end
    n_checks++; if (out_min_idx !== 4'd0 || out_max_idx !== 4'd0 || out_count !== 4'd1) begin
      n_fail++; $display("FAIL single_idx_count: got %0d/%0d/%0d want 0/0/1", out_min_idx, out_max_idx, out_count); end
    tick(2);
    n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL single_wait: ready=%b valid=%b want 0/1", in_ready, out_valid); end
    drain();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_after: got %b want 1", in_ready); end
  endtask

  task automatic test_signed();
    send(32'h7FFF_FFFF, 1'b0);
    send(32'h8000_0000, 1'b0);
    send(32'h0000_0000, 1'b1);
    n_checks++; if (out_min !== 32'h8000_0000 || out_min_idx !== 4'd1) begin
      n_fail++; $display("FAIL signed_min: got %h idx %0d want 80000000 idx 1", out_min, out_min_idx); end
    n_checks++; if (out_max !== 32'h7FFF_FFFF || out_max_idx !== 4'd0) begin
      n_fail++; $display("FAIL signed_max: got %h idx %0d want 7fffffff idx 0", out_max, out_max_idx); end
    n_checks++; if (out_count !== 4'd3) begin n_fail++; $display("FAIL signed_count: got %0d want 3", out_count); end
    drain();
  endtask

  // Tie packet {4,2,2,4}: first occurrences must win. Then backpressure.
  task automatic test_hold();
    send(32'd4, 1'b0);
    send(32'd2, 1'b0);
    send(32'd2, 1'b0);
    send(32'd4, 1'b1);
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_min !== 32'd2 || out_min_idx !== 4'd1 ||
          out_max !== 32'd4 || out_max_idx !== 4'd0 || out_count !== 4'd4) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: v=%b r=%b min=%0d@%0d max=%0d@%0d cnt=%0d want v=1 r=0 2@1 4@0 cnt=4",
                 c, out_valid, in_ready, $signed(out_min), out_min_idx, $signed(out_max), out_max_idx, out_count);
      end
      tick(1);
    end
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL hold_release: valid=%b ready=%b want 0/1", out_valid, in_ready); end
    n_checks++; if (out_min !== 32'd2 || out_max !== 32'd4 || out_count !== 4'd4) begin
      n_fail++; $display("FAIL hold_stable_after: got %0d/%0d/%0d want 2/4/4", $signed(out_min), $signed(out_max), out_count); end
  endtask

  // Bubbles carry junk data and a stray in_last that must be ignored.
  task automatic test_bubbles();
    send(32'd10, 1'b0);
    in_data = 32'h8000_0000; in_last = 1'b1;
    tick(2);
    send(-32'sd20, 1'b0);
    in_data = 32'h7FFF_FFFF; in_last = 1'b1;
    tick(3);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_valid: got %b want 0", out_valid); end
    send(32'd30, 1'b1);
    n_checks++; if (out_min !== 32'hFFFF_FFEC || out_min_idx !== 4'd1) begin
      n_fail++; $display("FAIL bubble_min: got %0d@%0d want -20@1", $signed(out_min), out_min_idx); end
    n_checks++; if (out_max !== 32'd30 || out_max_idx !== 4'd2 || out_count !== 4'd3) begin
      n_fail++; $display("FAIL bubble_max: got %0d@%0d cnt %0d want 30@2 cnt 3", $signed(out_max), out_max_idx, out_count); end
    drain();
  endtask

  // IDX_W=4: count saturates at 15, later samples are indexed 15.
  task automatic test_saturation();
    for (int k = 0; k < 15; k++) send(32'd0, 1'b0);
    send(-32'sd5, 1'b0);
    send(32'd9, 1'b0);
    send(32'd20, 1'b1);
    n_checks++; if (out_count !== 4'd15) begin n_fail++; $display("FAIL sat_count: got %0d want 15", out_count); end
    n_checks++; if (out_min !== 32'hFFFF_FFFB || out_min_idx !== 4'd15) begin
      n_fail++; $display("FAIL sat_min: got %0d@%0d want -5@15", $signed(out_min), out_min_idx); end
    n_checks++; if (out_max !== 32'd20 || out_max_idx !== 4'd15) begin
      n_fail++; $display("FAIL sat_max: got %0d@%0d want 20@15", $signed(out_max), out_max_idx); end
    drain();
  endtask

  task automatic test_reset_mid();
    send(32'd100, 1'b0);
    send(-32'sd100, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_min !== '0 || out_max !== '0 || out_count !== '0) begin
      n_fail++; $display("FAIL midreset_clear: v=%b min=%h max=%h cnt=%0d want all 0", out_valid, out_min, out_max, out_count); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);
    send(32'd1, 1'b0);
    send(32'd2, 1'b1);
    n_checks++; if (out_min !== 32'd1 || out_max !== 32'd2 || out_count !== 4'd2) begin
      n_fail++; $display("FAIL midreset_packet: got %0d/%0d/%0d want 1/2/2", $signed(out_min), $signed(out_max), out_count); end
    n_checks++; if (out_min_idx !== 4'd0 || out_max_idx !== 4'd1) begin
      n_fail++; $display("FAIL midreset_idx: got %0d/%0d want 0/1", out_min_idx, out_max_idx); end
    drain();
  endtask

  task automatic test_random();
    logic signed [N-1:0] d, m_min, m_max;
    logic [IDX_W-1:0]    m_min_idx, m_max_idx, m_cnt;
    int                  len;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 20);
      for (int s = 0; s < len; s++) begin
        if ($urandom_range(0, 2) == 0) d = N'($signed($urandom_range(0, 6)) - 3);
        else d = $urandom;
        if (s == 0) begin
          m_min = d; m_max = d; m_min_idx = '0; m_max_idx = '0; m_cnt = 4'd1;
        end else begin
          if (d < m_min) begin m_min = d; m_min_idx = m_cnt; end
          if (d > m_max) begin m_max = d; m_max_idx = m_cnt; end
          if (m_cnt != 4'd15) m_cnt = m_cnt + 4'd1;
        end
        in_data = $urandom; in_last = $urandom_range(0, 1) == 1;
        tick($urandom_range(0, 2));
        send(d, s == len - 1);
      end
      tick($urandom_range(0, 3));
      n_checks++;
      if (out_valid !== 1'b1 || out_min !== m_min || out_max !== m_max || out_min_idx !== m_min_idx ||
          out_max_idx !== m_max_idx || out_count !== m_cnt) begin
        n_fail++;
        $display("FAIL random_pkt%0d: v=%b min=%0d@%0d max=%0d@%0d cnt=%0d want v=1 min=%0d@%0d max=%0d@%0d cnt=%0d",
                 p, out_valid, $signed(out_min), out_min_idx, $signed(out_max), out_max_idx, out_count,
                 m_min, m_min_idx, m_max, m_max_idx, m_cnt);
      end
      drain();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_signed();
    test_hold();
    test_bubbles();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
